bus_cycle_controller: RTL
=========================

Name: bus_cycle_controller

Overview:
Sequences every external memory/IO bus cycle of the CPU and arbitrates the external bus between the CPU microcode and the DMA requester. It accepts one CPU transfer request at a time and produces the setup/strobe/hold timing for `addr`, `rd`, `wr`, `mem_io` and `data_out`, honouring `WAIT` with a timeout. It grants the bus to DMA only between CPU cycles, and it sits between the microcode sequencer/MAR/MDR datapath and the chip pins.

Parameters:
ADDR_WIDTH, 22, external address width.
SETUP_CYCLES, 1, cycles `addr`/`mem_io`/`data_out` are stable before the strobe; legal range 1..15.
STROBE_CYCLES, 2, minimum cycles `rd`/`wr` are asserted before `WAIT` is sampled; legal range 1..15.
WAIT_TIMEOUT, 255, maximum extra strobe cycles tolerated while `WAIT`=1; legal range 1..255.

Ports:
clk  in  1  system clock; all logic on the rising edge.
arst  in  1  asynchronous active-high reset.
cpu_req  in  1  CPU transfer request; sampled only in IDLE.
cpu_wr  in  1  1 = write, 0 = read; latched with cpu_req.
cpu_mem_io  in  1  1 = memory space, 0 = IO space; latched with cpu_req.
cpu_addr  in  ADDR_WIDTH  transfer address; latched with cpu_req.
cpu_wdata  in  8  write data; latched with cpu_req.
cpu_rdata  out  8  captured read data; holds until the next read completes.
cpu_done  out  1  one-cycle pulse; the transfer has finished.
bus_error  out  1  one-cycle pulse coincident with cpu_done on WAIT timeout.
dma_req  in  1  external DMA bus request, level.
dma_ack  out  1  bus granted to DMA; all bus outputs released.
WAIT  in  1  active-high strobe extension from a slow device.
data_in  in  8  external bus read data.
addr  out  ADDR_WIDTH  external address.
data_out  out  8  external write data.
data_oe  out  1  `data_out` drive enable; the pad layer converts it to tri-state.
rd  out  1  read strobe.
wr  out  1  write strobe.
mem_io  out  1  address space select.
bus_busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock `clk`; reset `arst` is asynchronous and active-high.
- Reset values: state = IDLE; all outputs 0, including `cpu_rdata` = 8'h00. The `dma_fair` flag and all counters are 0.
- Reset mid-cycle: `rd`, `wr`, `data_oe` and `dma_ack` drop immediately and asynchronously, with no `cpu_done`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- State IDLE:
  - If `dma_req`=1 and (`cpu_req`=0 or `dma_fair`=0), go to DMA.
  - Else if `cpu_req`=1, latch `cpu_wr`, `cpu_mem_io`, `cpu_addr`, `cpu_wdata` and go to SETUP. Clear `dma_fair`.
  - Simultaneous requests with `dma_fair`=0: DMA wins.
- State SETUP:
  - Drive `addr`, `mem_io`, and `data_out` with `data_oe`=`cpu_wr`; `rd`=`wr`=0.
  - After SETUP_CYCLES cycles, go to STROBE.
- State STROBE:
  - Assert `rd` (read) or `wr` (write); `addr`/`data_out` stay stable.
  - The counter runs for STROBE_CYCLES cycles, then `WAIT` is sampled each cycle.
  - `WAIT`=0: on that edge capture `cpu_rdata` <= `data_in` (reads only) and go to HOLD.
  - `WAIT`=1: stay and increment the wait counter.
  - Wait counter reaches WAIT_TIMEOUT: go to HOLD with the error flag set; on a read, `cpu_rdata` <= 8'hFF.
- State HOLD:
  - `rd`=`wr`=0; `addr`, `mem_io`, `data_out` and `data_oe` are still held.
  - `cpu_done`=1 for exactly this cycle; `bus_error`=1 if the error flag is set.
  - Next state is IDLE, where `addr` and `data_oe` return to 0.
- State DMA:
  - `dma_ack`=1; `addr`, `data_out`, `data_oe`, `rd`, `wr`, `mem_io` = 0.
  - When `dma_req`=0: `dma_ack` <= 0 and go to IDLE. Set `dma_fair`=1 if `cpu_req` is pending, so the CPU wins the next arbitration.
  - There is always at least one idle bus cycle between `dma_ack` falling and CPU `addr` driving.
- No preemption: `dma_req` arriving during SETUP/STROBE/HOLD waits until IDLE.
- `cpu_req` still high in the IDLE cycle after `cpu_done` starts a new transfer; the requester must drop it on `cpu_done` for single transfers.
- Latency with defaults and no WAIT:
  - `cpu_req` sampled at edge E0.
  - SETUP from E0 to E1; STROBE from E1 to E3.
  - `cpu_done` is high from E3 to E4.
  - Total 4 cycles request-to-done, plus 1 IDLE cycle before the next request.
- Counters are 4-bit (setup/strobe) and 8-bit (wait); they reset to 0 on every state entry and never wrap.

Test Plan:
1. Read, defaults, `WAIT`=0, addr 22'h012345, `mem_io`=1, `data_in`=8'hA5 → `rd` high exactly 2 cycles starting 1 cycle after SETUP entry; `cpu_done` 4 cycles after request; `cpu_rdata`=8'hA5; `data_oe`=0 throughout.
2. Write 8'h3C to IO addr 22'h000010 with `WAIT`=1 for 3 cycles after minimum strobe → `wr` high 5 cycles; `data_oe`=1 and `data_out`=8'h3C from SETUP through HOLD; `mem_io`=0; `bus_error`=0.
3. Read with `WAIT` held 1 and WAIT_TIMEOUT=4 → `rd` high 2+4 cycles; `cpu_done` and `bus_error` pulse together; `cpu_rdata`=8'hFF.
4. `dma_req` and `cpu_req` rise in the same IDLE cycle → `dma_ack`=1 next cycle with bus outputs 0. Release `dma_req` → `dma_ack`=0, then CPU SETUP starts. A re-asserted `dma_req` waits for `cpu_done`.
5. `dma_req` raised mid-STROBE of a read → `dma_ack` stays 0 until after HOLD; CPU read completes with correct data.
6. `arst` pulsed mid-STROBE of a write → `wr`/`data_oe` drop asynchronously; no `cpu_done`; after release, state is IDLE and a new read completes normally.

Source files
------------

// File: rtl/bus_cycle_controller.sv
// External bus cycle sequencer: SETUP/STROBE/HOLD timing for CPU transfers with WAIT
// extension and timeout, plus DMA arbitration that only grants the bus between CPU cycles.
module bus_cycle_controller #(
    parameter int ADDR_WIDTH    = 22,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int WAIT_TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  cpu_req,
    input  logic                  cpu_wr,
    input  logic                  cpu_mem_io,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_done,
    output logic                  bus_error,
    input  logic                  dma_req,
    output logic                  dma_ack,
    input  logic                  WAIT,
    input  logic [7:0]            data_in,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [7:0]            data_out,
    output logic                  data_oe,
    output logic                  rd,
    output logic                  wr,
    output logic                  mem_io,
    output logic                  bus_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DMA
    } state_t;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [7:0] WAIT_LIMIT  = 8'(WAIT_TIMEOUT);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [7:0]              wait_q, wait_d;
    logic                    fair_q, fair_d;
    logic                    err_q, err_d;
    logic                    lat_wr_q, lat_wr_d;
    logic                    lat_mio_q, lat_mio_d;
    logic [ADDR_WIDTH-1:0]   lat_addr_q, lat_addr_d;
    logic [7:0]              lat_wdata_q, lat_wdata_d;
    logic [7:0]              rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              dout_q, dout_d;
    logic                    oe_q, oe_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic                    mio_q, mio_d;
    logic                    ack_q, ack_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    berr_q, berr_d;
    logic                    cpu_phase;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        fair_d      = fair_q;
        err_d       = err_q;
        lat_wr_d    = lat_wr_q;
        lat_mio_d   = lat_mio_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        rdata_d     = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (dma_req && (!cpu_req || !fair_q)) begin
                    state_d = S_DMA;
                end else if (cpu_req) begin
                    lat_wr_d    = cpu_wr;
                    lat_mio_d   = cpu_mem_io;
                    lat_addr_d  = cpu_addr;
                    lat_wdata_d = cpu_wdata;
                    fair_d      = 1'b0;
                    err_d       = 1'b0;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) state_d = S_STROBE;
                else                     cnt_d   = cnt_q + 4'd1;
            end
            S_STROBE: begin
                // Minimum strobe width first; only then does WAIT matter.
                if (cnt_q != STROBE_LAST) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (!WAIT) begin
                    state_d = S_HOLD;
                    if (!lat_wr_q) rdata_d = data_in;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d = S_HOLD;
                    err_d   = 1'b1;
                    if (!lat_wr_q) rdata_d = 8'hFF;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_HOLD: state_d = S_IDLE;
            S_DMA: begin
                if (!dma_req) begin
                    state_d = S_IDLE;
                    fair_d  = cpu_req;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d  = 4'd0;
            wait_d = 8'd0;
        end

        // Outputs are decoded from the next state so the pins change on the state edge.
        cpu_phase = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        addr_d    = cpu_phase ? lat_addr_d : '0;
        mio_d     = cpu_phase && lat_mio_d;
        oe_d      = cpu_phase && lat_wr_d;
        dout_d    = oe_d ? lat_wdata_d : 8'h00;
        rd_d      = (state_d == S_STROBE) && !lat_wr_d;
        wr_d      = (state_d == S_STROBE) && lat_wr_d;
        ack_d     = (state_d == S_DMA);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_HOLD);
        berr_d    = done_d && err_d;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            wait_q      <= 8'd0;
            fair_q      <= 1'b0;
            err_q       <= 1'b0;
            lat_wr_q    <= 1'b0;
            lat_mio_q   <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= 8'h00;
            rdata_q     <= 8'h00;
            addr_q      <= '0;
            dout_q      <= 8'h00;
            oe_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            mio_q       <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            berr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            fair_q      <= fair_d;
            err_q       <= err_d;
            lat_wr_q    <= lat_wr_d;
            lat_mio_q   <= lat_mio_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            mio_q       <= mio_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            berr_q      <= berr_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_done  = done_q;
    assign bus_error = berr_q;
    assign dma_ack   = ack_q;
    assign addr      = addr_q;
    assign data_out  = dout_q;
    assign data_oe   = oe_q;
    assign rd        = rd_q;
    assign wr        = wr_q;
    assign mem_io    = mio_q;
    assign bus_busy  = busy_q;

endmodule
